ivector_heard_serializer: RTL and testbench
===========================================

Name: ivector_heard_serializer

Overview:
- Consumer end of the ivector `heard` indication.
- Accepts one 704-bit `heard` vector per transaction into a holding register.
- Streams it to the host indication pipe as one 32-bit header word followed by 22 payload words, LSB word first.
- Sits between the ivector block's `ind$heard` port and the 32-bit indication FIFO that feeds the portal.

Parameters:
- DATA_WIDTH, 704, width of the `heard` vector; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, width of each pipe word.
- METHOD_ID, 0, 16-bit method identifier placed in the header's upper half.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- nRST  input  1  reset; synchronous and active-high (asserted = 1), sampled on the CLK rising edge.
- heard__ENA  input  1  heard method enable; asserted by the producer only while heard__RDY=1.
- heard_heard_v  input  DATA_WIDTH  vector payload, valid with heard__ENA.
- heard__RDY  output  1  block can accept a heard transaction this cycle.
- pipe$enq__ENA  output  1  word transferred to the indication pipe this cycle.
- pipe$enq_v  output  WORD_WIDTH  word being enqueued.
- pipe$enq__RDY  input  1  indication pipe can accept a word.
- msg_count  output  32  number of messages fully emitted since reset; wraps modulo 2^32.

Behaviour:
- Constants:
  - WORDS = DATA_WIDTH/WORD_WIDTH = 22.
  - Header = {METHOD_ID[15:0], LEN[15:0]}, with LEN = WORDS+1 = 23.
- State: buf (DATA_WIDTH), idx (5 bits, 0..WORDS-1), state in {IDLE, HDR, DATA}, msg_count.
- Reset (nRST=1 at a clock edge):
  - state=IDLE, idx=0, buf=0, msg_count=0.
  - Outputs during and after reset: heard__RDY=1 (IDLE), pipe$enq__ENA=0, pipe$enq_v=0.
  - Reset mid-message abandons the message: no further words are emitted, and msg_count is not incremented.
- Pipe output:
  - pipe$enq_v = header in HDR; buf[idx*32 +: 32] in DATA; 0 in IDLE.
  - pipe$enq__ENA = (state != IDLE) && pipe$enq__RDY. ENA is never asserted without RDY. A word is transferred exactly when ENA=1.
- heard__RDY = (state==IDLE) || (state==DATA && idx==WORDS-1 && pipe$enq__RDY). This second term is the back-to-back accept.
- Transitions (per clock, when not in reset):
  - IDLE:
    - heard__ENA=1 → buf<=heard_heard_v, state<=HDR.
    - Otherwise hold.
  - HDR:
    - pipe transfer → state<=DATA, idx<=0.
    - Stall (RDY=0) → hold; header is re-presented unchanged.
  - DATA with transfer and idx<WORDS-1 → idx<=idx+1.
  - DATA with transfer and idx==WORDS-1:
    - msg_count<=msg_count+1.
    - If heard__ENA=1 the same cycle: buf<=new vector, state<=HDR.
    - Else: state<=IDLE.
  - DATA with no transfer → hold all state.
- Latency and throughput:
  - heard accepted at cycle t → header ENA no earlier than t+1.
  - First payload word no earlier than t+2.
  - Last payload word at t+23 with continuous RDY.
  - Sustained throughput with RDY=1: one message per 23 cycles, no bubble.
- buf is written only on an accepted heard. Payload words always come from the vector captured at accept, independent of later heard_heard_v changes.
- heard__ENA asserted while heard__RDY=0 is a protocol violation; the block ignores it and leaves all state unchanged.

Decomposition:
- Shared package ivector_pkg holds:
  - DATA_WIDTH and WORD_WIDTH defaults.
  - WORDS and LEN constants.
  - State enum {IDLE, HDR, DATA}.
  - The header-format function build_header(method_id, len).
- The ivector block and the host-side request deserializer (the opposite path) both use ivector_pkg.
- No sub-module; the word mux and FSM form a single module.

Test Plan:
- Single message:
  - Stimulus: reset 2 cycles; heard with v[31:0]=0x11111111, v[63:32]=0x22222222, …, v[703:672]=0x16161616; RDY tied 1.
  - Required response: words 0x00000017, 0x11111111, 0x22222222 … 0x16161616 on 23 consecutive ENA cycles; msg_count=1; heard__RDY back to 1.
- Backpressure:
  - Stimulus: RDY toggles 1,0,0,1 repeating during the same message.
  - Required response: identical 23-word sequence; no word duplicated or dropped; ENA=0 on every RDY=0 cycle; pipe$enq_v stable across stalls.
- Back-to-back:
  - Stimulus: second heard (all words 0xA5A5A5A5) presented at the cycle of the last payload word, RDY=1.
  - Required response: heard__RDY=1 that cycle; next cycle emits header 0x00000017; 46 words in 46 cycles; msg_count=2.
- Input isolation:
  - Stimulus: change heard_heard_v to all-ones while a message is being emitted.
  - Required response: emitted payload unchanged; heard__RDY stays 0 until the last word.
- Reset mid-message:
  - Stimulus: assert nRST=1 after payload word 5.
  - Required response: next cycle ENA=0 and heard__RDY=1; msg_count=0; a following heard emits a complete fresh 23-word message.
- METHOD_ID parameter:
  - Stimulus: METHOD_ID=0x0003.
  - Required response: header word = 0x00030017.

Source files
------------

// File: rtl/ivector_pkg.sv
// Shared constants, FSM state type and header format for the ivector host-pipe serializers.
package ivector_pkg;

    localparam int DATA_WIDTH_DEF = 704;
    localparam int WORD_WIDTH_DEF = 32;
    localparam int WORDS          = DATA_WIDTH_DEF / WORD_WIDTH_DEF;
    localparam int LEN            = WORDS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Header layout: method id in the upper half, total word count (header included) in the lower half.
    function automatic logic [31:0] build_header(input logic [15:0] method_id,
                                                 input logic [15:0] len);
        return {method_id, len};
    endfunction

endpackage

// File: rtl/ivector_heard_serializer_if.sv
// Heard-method handshake plus indication-pipe enqueue port; master = producer/host side, slave = serializer.
interface ivector_heard_serializer_if #(
    parameter int DATA_WIDTH = 704,
    parameter int WORD_WIDTH = 32
);
    logic                  heard__ENA;
    logic [DATA_WIDTH-1:0] heard_heard_v;
    logic                  heard__RDY;
    logic                  pipe_enq__ENA;
    logic [WORD_WIDTH-1:0] pipe_enq_v;
    logic                  pipe_enq__RDY;

    modport master (
        output heard__ENA,
        output heard_heard_v,
        output pipe_enq__RDY,
        input  heard__RDY,
        input  pipe_enq__ENA,
        input  pipe_enq_v
    );

    modport slave (
        input  heard__ENA,
        input  heard_heard_v,
        input  pipe_enq__RDY,
        output heard__RDY,
        output pipe_enq__ENA,
        output pipe_enq_v
    );
endinterface

// File: rtl/ivector_heard_serializer.sv
// Captures one heard vector and streams header + payload words (LSB word first) into the indication pipe.
// Header one cycle after accept; a new vector may be accepted on the last payload word (no bubble).
module ivector_heard_serializer
    import ivector_pkg::*;
#(
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int          WORD_WIDTH = WORD_WIDTH_DEF,
    parameter logic [15:0] METHOD_ID  = 16'h0000
) (
    input  logic                     CLK,
    input  logic                     nRST,
    ivector_heard_serializer_if.slave bus,
    output logic [31:0]              msg_count
);

    localparam int                    NWORDS   = DATA_WIDTH / WORD_WIDTH;
    localparam int                    IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [WORD_WIDTH-1:0] HDR_WORD =
        WORD_WIDTH'(build_header(METHOD_ID, 16'(NWORDS + 1)));

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [31:0]           msg_count_q, msg_count_d;

    logic                  heard_rdy;
    logic                  enq_ena;
    logic [WORD_WIDTH-1:0] enq_word;
    logic                  accept;
    logic                  last_word;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            msg_count_q <= msg_count_d;
        end
    end

    // A heard__ENA seen while not ready is a producer error and is dropped here.
    assign accept    = bus.heard__ENA && heard_rdy;
    assign last_word = (state_q == DATA) && (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        msg_count_d = msg_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = bus.heard_heard_v;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (enq_ena) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (enq_ena) begin
                    if (last_word) begin
                        msg_count_d = msg_count_q + 32'd1;
                        if (accept) begin
                            hold_d  = bus.heard_heard_v;
                            state_d = HDR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        heard_rdy = (state_q == IDLE) || (last_word && bus.pipe_enq__RDY);
        enq_ena   = (state_q != IDLE) && bus.pipe_enq__RDY;
        enq_word  = '0;
        case (state_q)
            HDR:     enq_word = HDR_WORD;
            DATA:    enq_word = hold_q[int'(idx_q) * WORD_WIDTH +: WORD_WIDTH];
            default: enq_word = '0;
        endcase
    end

    assign bus.heard__RDY    = heard_rdy;
    assign bus.pipe_enq__ENA = enq_ena;
    assign bus.pipe_enq_v    = enq_word;
    assign msg_count         = msg_count_q;

endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Directed + random checks of the heard serializer against a pending-word queue model.
module tb_ivector_heard_serializer;

    localparam logic [31:0] HDR0 = {16'h0000, 16'd23};
    localparam logic [31:0] HDR3 = {16'h0003, 16'd23};

    typedef struct {
        logic [31:0] w;
        bit          hdr;
    } word_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic [31:0] msg_count0, msg_count1;

    ivector_heard_serializer_if #(.DATA_WIDTH(704), .WORD_WIDTH(32)) bus0 ();
    ivector_heard_serializer_if #(.DATA_WIDTH(704), .WORD_WIDTH(32)) bus1 ();

    assign bus1.heard__ENA    = bus0.heard__ENA;
    assign bus1.heard_heard_v = bus0.heard_heard_v;
    assign bus1.pipe_enq__RDY = bus0.pipe_enq__RDY;

    ivector_heard_serializer #(.DATA_WIDTH(704), .WORD_WIDTH(32), .METHOD_ID(16'h0000)) dut0 (
        .CLK(CLK), .nRST(nRST), .bus(bus0), .msg_count(msg_count0));
    ivector_heard_serializer #(.DATA_WIDTH(704), .WORD_WIDTH(32), .METHOD_ID(16'h0003)) dut1 (
        .CLK(CLK), .nRST(nRST), .bus(bus1), .msg_count(msg_count1));

    always #5 CLK = ~CLK;

    int    total = 0;
    int    bad = 0;
    word_t q[$];
    int    msgs = 0;
    bit    last_xfer;
    bit    obs_hrdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_msg(input logic [703:0] v);
        q.push_back('{w: HDR0, hdr: 1'b1});
        for (int i = 0; i < 22; i++) q.push_back('{w: v[i*32 +: 32], hdr: 1'b0});
    endfunction

    // ena_mode: 0 = idle, 1 = request only when the model says ready, 2 = assert regardless
    task automatic tick(input bit rdy, input int ena_mode, input logic [703:0] v, input bit rst);
        bit rdy_exp;
        bit ena;
        bit xfer;
        rdy_exp = (q.size() == 0) || (q.size() == 1 && rdy);
        ena = (ena_mode == 2) || (ena_mode == 1 && rdy_exp);
        nRST = rst;
        bus0.pipe_enq__RDY = rdy;
        bus0.heard__ENA = ena;
        bus0.heard_heard_v = v;
        @(negedge CLK);
        obs_hrdy = bus0.heard__RDY;
        if (!rst) begin
            chk("enq_ena", 32'(bus0.pipe_enq__ENA), 32'((q.size() != 0) && rdy));
            if (q.size() != 0) chk("enq_v", bus0.pipe_enq_v, q[0].w);
            else chk("enq_v_idle", bus0.pipe_enq_v, 32'h0);
            chk("heard_rdy", 32'(bus0.heard__RDY), 32'(rdy_exp));
            chk("msg_count", msg_count0, 32'(msgs));
            if (q.size() != 0 && q[0].hdr) chk("hdr_mid3", bus1.pipe_enq_v, HDR3);
        end
        @(posedge CLK);
        #1;
        last_xfer = 1'b0;
        if (rst) begin
            q.delete();
            msgs = 0;
        end else begin
            xfer = (q.size() != 0) && rdy;
            last_xfer = xfer;
            if (xfer) begin
                void'(q.pop_front());
                if (q.size() == 0) msgs++;
            end
            if (ena && rdy_exp) push_msg(v);
        end
    endtask

    function automatic logic [703:0] rand_vec();
        logic [703:0] r;
        for (int i = 0; i < 22; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [703:0] v1, va, vr, ones;
        int n;
        int base;
        for (int i = 0; i < 22; i++) v1[i*32 +: 32] = {4{8'(i + 1)}};
        va = {22{32'hA5A5A5A5}};
        ones = '1;
        bus0.heard__ENA = 1'b0;
        bus0.heard_heard_v = '0;
        bus0.pipe_enq__RDY = 1'b1;

        repeat (2) tick(1'b1, 0, '0, 1'b1);
        repeat (2) tick(1'b1, 0, '0, 1'b0);

        // single message, RDY held high
        tick(1'b1, 1, v1, 1'b0);
        n = 0;
        repeat (25) begin
            tick(1'b1, 0, v1, 1'b0);
            n += int'(last_xfer);
        end
        chk("single_words", 32'(n), 32'd23);
        chk("single_count", msg_count0, 32'd1);

        // backpressure pattern 1,0,0,1
        tick(1'b1, 1, v1, 1'b0);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            tick((c % 4 == 0) || (c % 4 == 3), 0, v1, 1'b0);
            n += int'(last_xfer);
        end
        chk("bp_words", 32'(n), 32'd23);

        // back-to-back accept on the last payload word
        base = msgs;
        tick(1'b1, 1, v1, 1'b0);
        repeat (22) tick(1'b1, 0, v1, 1'b0);
        tick(1'b1, 1, va, 1'b0);
        chk("b2b_rdy", 32'(obs_hrdy), 32'd1);
        n = 0;
        repeat (23) begin
            tick(1'b1, 0, va, 1'b0);
            n += int'(last_xfer);
        end
        chk("b2b_words", 32'(n), 32'd23);
        chk("b2b_count", msg_count0, 32'(base + 2));
        repeat (2) tick(1'b1, 0, va, 1'b0);

        // input isolation plus ignored heard__ENA while busy
        vr = rand_vec();
        tick(1'b1, 1, vr, 1'b0);
        repeat (5) tick(1'b1, 0, ones, 1'b0);
        repeat (3) tick(1'b1, 2, ones, 1'b0);
        repeat (20) tick(1'b1, 0, ones, 1'b0);

        // reset after payload word 5
        vr = rand_vec();
        tick(1'b1, 1, vr, 1'b0);
        repeat (7) tick(1'b1, 0, vr, 1'b0);
        tick(1'b1, 0, vr, 1'b1);
        tick(1'b1, 0, vr, 1'b0);
        chk("rst_ena", 32'(bus0.pipe_enq__ENA), 32'd0);
        chk("rst_rdy", 32'(bus0.heard__RDY), 32'd1);
        chk("rst_count", msg_count0, 32'd0);
        tick(1'b1, 1, v1, 1'b0);
        n = 0;
        repeat (25) begin
            tick(1'b1, 0, v1, 1'b0);
            n += int'(last_xfer);
        end
        chk("rst_fresh_words", 32'(n), 32'd23);
        chk("rst_fresh_count", msg_count0, 32'd1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 9);
            tick($urandom_range(0, 3) != 0, (r < 5) ? 1 : ((r == 9) ? 2 : 0), rand_vec(), 1'b0);
        end
        repeat (40) tick(1'b1, 0, '0, 1'b0);
        chk("final_count", msg_count0, 32'(msgs));
        chk("final_count_m3", msg_count1, 32'(msgs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
